// File: rtl/machine_mode_types_1_12_pkg.sv
// machine_mode_types_1_12_pkg: shared types and constants for the 1.12 privilege block.
package machine_mode_types_1_12_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, INSERT} pipe_ctrl_state_t;
  typedef enum logic {TRAP, RET} redirect_kind_t;
  localparam logic [1:0] DIRECT = 2'd0;
  localparam logic [1:0] VECTORED = 2'd1;
endpackage

// File: rtl/priv_1_12_pipe_ctrl_if.sv
// priv_1_12_pipe_ctrl_if: trap/return request and fetch redirect bundle.
interface priv_1_12_pipe_ctrl_if;
  logic intr;
  logic mret;
  logic sret;
  logic uret;
  logic pipe_clear;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mcause;
  logic [31:0] curr_mepc;
  logic insert_pc;
  logic [31:0] priv_pc;
  logic busy;
  modport master (
    output intr, mret, sret, uret, pipe_clear, curr_mtvec, curr_mcause, curr_mepc,
    input  insert_pc, priv_pc, busy
  );
  modport slave (
    input  intr, mret, sret, uret, pipe_clear, curr_mtvec, curr_mcause, curr_mepc,
    output insert_pc, priv_pc, busy
  );
endinterface

// File: rtl/priv_1_12_trap_target.sv
// priv_1_12_trap_target: combinational redirect target for trap entry or return.
module priv_1_12_trap_target
  import machine_mode_types_1_12_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1,
  parameter int IALIGN = 32
) (
  input  logic [31:0]    mtvec_i,
  input  logic [31:0]    mcause_i,
  input  logic [31:0]    mepc_i,
  input  redirect_kind_t kind_i,
  output logic [31:0]    target_o
);
  logic [31:0] base;
  logic [31:0] ret_pc;
  logic        vec;
  always_comb begin
    base = {mtvec_i[31:2], 2'b00};
    vec = VECTORED_EN && (mtvec_i[1:0] == VECTORED) && mcause_i[31];
    ret_pc = mepc_i & ~((IALIGN == 16) ? 32'd1 : 32'd3);
    target_o = (kind_i == RET) ? ret_pc : vec ? base + 32'({mcause_i[30:0], 2'b00}) : base;
  end
endmodule

// File: rtl/priv_1_12_pipe_ctrl.sv
// priv_1_12_pipe_ctrl: waits for pipeline drain, then redirects fetch for trap entry/return.
module priv_1_12_pipe_ctrl
  import machine_mode_types_1_12_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1,
  parameter int IALIGN = 32
) (
  input logic CLK,
  input logic nRST,
  priv_1_12_pipe_ctrl_if.slave bus
);
  pipe_ctrl_state_t state_q;
  redirect_kind_t   kind_q;
  redirect_kind_t   kind_d;
  logic             insert_q;
  logic [31:0]      priv_pc_q;
  logic [31:0]      target;
  logic             req;
  // An interrupt arriving while a return waits takes over, even on the drain cycle itself.
  assign req = bus.intr | bus.mret;
  assign kind_d = bus.intr ? TRAP : kind_q;
  priv_1_12_trap_target #(.VECTORED_EN(VECTORED_EN), .IALIGN(IALIGN)) u_target (
    .mtvec_i(bus.curr_mtvec),
    .mcause_i(bus.curr_mcause),
    .mepc_i(bus.curr_mepc),
    .kind_i(kind_d),
    .target_o(target)
  );
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      kind_q <= TRAP;
      insert_q <= 1'b0;
      priv_pc_q <= 32'h0;
    end else begin
      insert_q <= 1'b0;
      unique case (state_q)
        IDLE, INSERT: if (req) begin
          kind_q <= bus.intr ? TRAP : RET;
          state_q <= WAIT;
        end else state_q <= IDLE;
        WAIT: begin
          kind_q <= kind_d;
          if (bus.pipe_clear) begin
            priv_pc_q <= target;
            insert_q <= 1'b1;
            state_q <= INSERT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.insert_pc = insert_q;
  assign bus.priv_pc = priv_pc_q;
  assign bus.busy = state_q != IDLE;
endmodule
